// File: rtl/controle_passos.sv
// Step sequencer ahead of the PWM stage: holds largura high for exactly N PWM periods,
// aligned to the period boundaries, with direction setup before and a settle pause after.
module controle_passos #(
  parameter int unsigned conf_periodo   = 1250,
  parameter int unsigned periodos_setup = 1,
  parameter int unsigned periodos_pausa = 4,
  parameter int unsigned largura_passos = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic [largura_passos-1:0] num_passos,
  input  logic                      direcao,
  input  logic                      parar,
  output logic                      largura,
  output logic                      direcao_out,
  output logic                      ocupado,
  output logic                      pronto,
  output logic [largura_passos-1:0] passos_feitos
);

  typedef enum logic [1:0] {OCIOSO, SETUP, PASSOS, PAUSA} estado_t;

  localparam logic [largura_passos-1:0] UM = largura_passos'(1);

  estado_t                   estado_q, estado_d;
  logic [31:0]               contagem_q, contagem_d;
  logic [31:0]               periodos_q, periodos_d;
  logic [largura_passos-1:0] restante_q, restante_d;
  logic [largura_passos-1:0] feitos_q, feitos_d;
  logic                      largura_q, largura_d;
  logic                      dir_q, dir_d;
  logic                      ocupado_q, ocupado_d;
  logic                      pronto_q, pronto_d;
  logic                      fim_periodo;
  logic                      terminar;

  assign fim_periodo = (contagem_q == 32'(conf_periodo - 1));

  always_comb begin
    contagem_d = fim_periodo ? 32'd0 : contagem_q + 32'd1;
    estado_d   = estado_q;
    periodos_d = periodos_q;
    restante_d = restante_q;
    feitos_d   = feitos_q;
    largura_d  = largura_q;
    dir_d      = dir_q;
    ocupado_d  = ocupado_q;
    pronto_d   = 1'b0;
    terminar   = 1'b0;

    case (estado_q)
      OCIOSO: begin
        // the pronto cycle is not an acceptance window
        if (iniciar && !pronto_q) begin
          if (num_passos != '0) begin
            restante_d = num_passos;
            dir_d      = direcao;
            feitos_d   = '0;
            ocupado_d  = 1'b1;
            periodos_d = 32'(periodos_setup);
            estado_d   = SETUP;
          end else begin
            pronto_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (parar) begin
          terminar = 1'b1;
        end else if (fim_periodo) begin
          periodos_d = periodos_q - 32'd1;
          if (periodos_q == 32'd1) begin
            largura_d = 1'b1;
            estado_d  = PASSOS;
          end
        end
      end
      PASSOS: begin
        // a boundary coinciding with parar still counts: the PWM stage saw largura=1
        if (fim_periodo) begin
          restante_d = restante_q - UM;
          feitos_d   = feitos_q + UM;
          if (restante_q == UM) terminar = 1'b1;
        end
        if (parar) terminar = 1'b1;
      end
      PAUSA: begin
        if (fim_periodo) begin
          periodos_d = periodos_q - 32'd1;
          if (periodos_q == 32'd1) begin
            pronto_d  = 1'b1;
            ocupado_d = 1'b0;
            estado_d  = OCIOSO;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase

    if (terminar) begin
      largura_d = 1'b0;
      if (periodos_pausa > 0) begin
        periodos_d = 32'(periodos_pausa);
        estado_d   = PAUSA;
      end else begin
        pronto_d  = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      contagem_q <= '0;
      periodos_q <= '0;
      restante_q <= '0;
      feitos_q   <= '0;
      largura_q  <= 1'b0;
      dir_q      <= 1'b0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contagem_q <= contagem_d;
      periodos_q <= periodos_d;
      restante_q <= restante_d;
      feitos_q   <= feitos_d;
      largura_q  <= largura_d;
      dir_q      <= dir_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
    end
  end

  assign largura       = largura_q;
  assign direcao_out   = dir_q;
  assign ocupado       = ocupado_q;
  assign pronto        = pronto_q;
  assign passos_feitos = feitos_q;

endmodule

// File: tb/tb_controle_passos.sv
// Bench for controle_passos: expected outputs derived from boundary arithmetic per move.
module tb_controle_passos;

  localparam int P  = 10;
  localparam int S  = 1;
  localparam int Z  = 2;
  localparam int W  = 16;
  localparam int S2 = 2;
  localparam int W2 = 3;

  logic          clock, reset, iniciar, direcao, parar;
  logic [W-1:0]  num_passos, passos_feitos;
  logic          largura, direcao_out, ocupado, pronto;
  logic          iniciar2, dir2, parar2;
  logic [W2-1:0] num2, passos2;
  logic          largura2, dir_out2, ocupado2, pronto2;

  int     vectors = 0;
  int     miscompares = 0;
  longint ecount = 0;
  logic [W-1:0] exp_pf = '0;
  logic         exp_dir = 1'b0;

  // downstream PWM stage: samples largura at period boundaries, 3-clock pulse
  int   pcnt = 0;
  logic sel = 1'b0, pwm, pwm_prev = 1'b0;
  int   pwm_pulses = 0, pwm_hi = 0;

  controle_passos #(.conf_periodo(P), .periodos_setup(S), .periodos_pausa(Z),
                    .largura_passos(W)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .num_passos(num_passos),
    .direcao(direcao), .parar(parar), .largura(largura), .direcao_out(direcao_out),
    .ocupado(ocupado), .pronto(pronto), .passos_feitos(passos_feitos));

  controle_passos #(.conf_periodo(P), .periodos_setup(S2), .periodos_pausa(0),
                    .largura_passos(W2)) dut2 (
    .clock(clock), .reset(reset), .iniciar(iniciar2), .num_passos(num2),
    .direcao(dir2), .parar(parar2), .largura(largura2), .direcao_out(dir_out2),
    .ocupado(ocupado2), .pronto(pronto2), .passos_feitos(passos2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  always @(posedge clock) begin
    if (reset) begin
      pcnt <= 0;
      sel  <= 1'b0;
    end else begin
      pcnt <= (pcnt == P - 1) ? 0 : pcnt + 1;
      if (pcnt == P - 1) sel <= largura;
    end
  end
  assign pwm = sel && (pcnt < 3);

  always @(negedge clock) begin
    if (pwm && !pwm_prev) pwm_pulses++;
    if (pwm) pwm_hi++;
    pwm_prev = pwm;
  end

  // first boundary edge strictly after edge e
  function automatic longint next_b(input longint e);
    longint m;
    m = e % P;
    return (m == P - 1) ? e + P : e + (P - 1 - m);
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    vectors += 7;
    if (largura !== 1'b0) begin miscompares++; $display("FAIL reset_largura got=%b exp=0", largura); end
    if (ocupado !== 1'b0) begin miscompares++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
    if (pronto !== 1'b0) begin miscompares++; $display("FAIL reset_pronto got=%b exp=0", pronto); end
    if (passos_feitos !== '0) begin miscompares++; $display("FAIL reset_passos got=%0d exp=0", passos_feitos); end
    if (direcao_out !== 1'b0) begin miscompares++; $display("FAIL reset_direcao got=%b exp=0", direcao_out); end
    if (largura2 !== 1'b0) begin miscompares++; $display("FAIL reset_largura2 got=%b exp=0", largura2); end
    if (ocupado2 !== 1'b0) begin miscompares++; $display("FAIL reset_ocupado2 got=%b exp=0", ocupado2); end
    exp_pf  = '0;
    exp_dir = 1'b0;
  endtask

  // One request; edge ids count posedges since reset release. Aborts at edge
  // b_{stop_bnd} (boundary index from acceptance) or at a+stop_off when nonzero.
  task automatic test_move(input int n, input bit d, input int stop_bnd, input int stop_off,
                           input bit hold);
    longint a, b1, r, f, p, endm, q, e, t, k;
    logic [W-1:0] pf0, epf;
    logic d0, ed, el, eo, ep;
    pf0 = exp_pf;
    d0  = exp_dir;
    num_passos = n[W-1:0];
    direcao = d;
    iniciar = 1'b1;
    parar   = 1'b0;
    a  = ecount;
    b1 = next_b(a);
    r  = b1 + longint'(S - 1) * P;
    f  = b1 + longint'(S + n - 1) * P;
    p  = longint'(1) << 60;
    if (stop_bnd > 0) p = b1 + longint'(stop_bnd - 1) * P;
    else if (stop_off > 0) p = a + stop_off;
    endm = (p < f) ? p : f;
    if (n == 0) q = a;
    else if (Z == 0) q = endm;
    else q = next_b(endm) + longint'(Z - 1) * P;
    epf = pf0;
    ed  = d0;
    do begin
      @(negedge clock);
      e = ecount - 1;
      if (!hold) iniciar = 1'b0;
      el = (n != 0) && (e >= r) && (e < endm);
      eo = (n != 0) && (e < q);
      ep = (e == q);
      t  = (e < p) ? e : p;
      if (n == 0) epf = pf0;
      else if (t < b1 + longint'(S) * P) epf = '0;
      else begin
        k = (t - (b1 + longint'(S) * P)) / P + 1;
        if (k > n) k = n;
        epf = k[W-1:0];
      end
      ed = (n == 0) ? d0 : d;
      vectors += 5;
      if (largura !== el) begin miscompares++; $display("FAIL largura n=%0d edge=%0d got=%b exp=%b", n, e, largura, el); end
      if (ocupado !== eo) begin miscompares++; $display("FAIL ocupado n=%0d edge=%0d got=%b exp=%b", n, e, ocupado, eo); end
      if (pronto !== ep) begin miscompares++; $display("FAIL pronto n=%0d edge=%0d got=%b exp=%b", n, e, pronto, ep); end
      if (passos_feitos !== epf) begin miscompares++; $display("FAIL passos_feitos n=%0d edge=%0d got=%0d exp=%0d", n, e, passos_feitos, epf); end
      if (direcao_out !== ed) begin miscompares++; $display("FAIL direcao_out n=%0d edge=%0d got=%b exp=%b", n, e, direcao_out, ed); end
      parar = (ecount == p);
      if (hold && pronto) iniciar = 1'b0;
    end while (e < q + 3);
    parar   = 1'b0;
    iniciar = 1'b0;
    exp_pf  = epf;
    exp_dir = ed;
  endtask

  task automatic test_basic;
    while (ecount % P != 3) @(negedge clock);
    test_move(3, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_zero;
    test_move(0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_abort;
    test_move(5, 1'b0, S + 2, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    test_move(2, 1'b1, 0, 0, 1'b1);
    test_move(3, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    int n, off;
    bit d, h;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clock);
      n   = $urandom_range(0, 6);
      d   = 1'($urandom_range(0, 1));
      off = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0;
      h   = (n != 0) && ($urandom_range(0, 1) == 1);
      test_move(n, d, 0, off, h);
    end
  endtask

  task automatic test_pwm;
    int p0, h0;
    p0 = pwm_pulses;
    h0 = pwm_hi;
    test_move(4, 1'b1, 0, 0, 1'b0);
    repeat (3 * P) @(negedge clock);
    vectors += 2;
    if (pwm_pulses - p0 !== 4) begin miscompares++; $display("FAIL pwm_pulses got=%0d exp=4", pwm_pulses - p0); end
    if (pwm_hi - h0 !== 12) begin miscompares++; $display("FAIL pwm_high_clocks got=%0d exp=12", pwm_hi - h0); end
  endtask

  // narrow counter, all-ones request, no pause: pronto lands on the last step edge
  task automatic test_small_width;
    int hi_cnt, pr_cnt;
    longint a, b1, f, e, pr_e;
    num2 = 3'd7;
    dir2 = 1'b1;
    iniciar2 = 1'b1;
    a  = ecount;
    b1 = next_b(a);
    f  = b1 + longint'(S2 + 6) * P;
    hi_cnt = 0;
    pr_cnt = 0;
    pr_e   = -1;
    do begin
      @(negedge clock);
      e = ecount - 1;
      iniciar2 = 1'b0;
      if (largura2) hi_cnt++;
      if (pronto2) begin pr_cnt++; pr_e = e; end
    end while (e < f + 3);
    vectors += 5;
    if (hi_cnt !== 7 * P) begin miscompares++; $display("FAIL w3_high_clocks got=%0d exp=%0d", hi_cnt, 7 * P); end
    if (pr_cnt !== 1) begin miscompares++; $display("FAIL w3_pronto_count got=%0d exp=1", pr_cnt); end
    if (pr_e !== f) begin miscompares++; $display("FAIL w3_pronto_edge got=%0d exp=%0d", pr_e, f); end
    if (passos2 !== 3'd7) begin miscompares++; $display("FAIL w3_passos got=%0d exp=7", passos2); end
    if (ocupado2 !== 1'b0) begin miscompares++; $display("FAIL w3_ocupado got=%b exp=0", ocupado2); end
  endtask

  task automatic test_reset_mid;
    longint a, b1;
    num_passos = 16'd4;
    direcao = 1'b1;
    iniciar = 1'b1;
    a  = ecount;
    b1 = next_b(a);
    while (ecount - 1 < b1 + longint'(S) * P + 2) begin
      @(negedge clock);
      iniciar = 1'b0;
    end
    vectors += 2;
    if (largura !== 1'b1) begin miscompares++; $display("FAIL mid_largura got=%b exp=1", largura); end
    if (passos_feitos !== 16'd1) begin miscompares++; $display("FAIL mid_passos got=%0d exp=1", passos_feitos); end
    reset = 1'b1;
    @(negedge clock);
    vectors += 5;
    if (largura !== 1'b0) begin miscompares++; $display("FAIL rst_largura got=%b exp=0", largura); end
    if (ocupado !== 1'b0) begin miscompares++; $display("FAIL rst_ocupado got=%b exp=0", ocupado); end
    if (pronto !== 1'b0) begin miscompares++; $display("FAIL rst_pronto got=%b exp=0", pronto); end
    if (passos_feitos !== '0) begin miscompares++; $display("FAIL rst_passos got=%0d exp=0", passos_feitos); end
    if (direcao_out !== 1'b0) begin miscompares++; $display("FAIL rst_direcao got=%b exp=0", direcao_out); end
    reset = 1'b0;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clock);
      vectors++;
      if ((pronto | largura | ocupado) !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle cyc=%0d got=%b%b%b exp=000", i, pronto, largura, ocupado);
      end
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; num_passos = '0; direcao = 1'b0; parar = 1'b0;
    iniciar2 = 1'b0; num2 = '0; dir2 = 1'b0; parar2 = 1'b0;
    repeat (3) @(negedge clock);
    test_reset;
    test_basic;
    test_zero;
    test_abort;
    test_back_to_back;
    test_random;
    test_pwm;
    test_small_width;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
